router_out_arbiter: RTL and testbench

//  Output-port arbiter/scheduler for one port of the five-port mesh router.

---
 rtl/router_out_arbiter_if.sv | 14 +
 rtl/router_out_arbiter.sv | 138 +++++++++++++
 tb/tb_router_out_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/router_out_arbiter_if.sv
// Request bundle between the five router inputs and one output-port arbiter.
// The master side presents flits; the slave (arbiter) answers with a one-hot ready.
interface router_out_arbiter_if #(
  parameter int NPORTS = 5,
  parameter int W      = 256
);
  logic [NPORTS-1:0]        req_valid;
  logic [NPORTS-1:0]        req_last;
  logic [NPORTS-1:0][W-1:0] req_packet;
  logic [NPORTS-1:0]        req_ready;

  modport master (output req_valid, req_last, req_packet, input  req_ready);
  modport slave  (input  req_valid, req_last, req_packet, output req_ready);
endinterface

// File: rtl/router_out_arbiter.sv
// Round-robin output-port arbiter with packet locking, credit metering and a
// single registered output stage carrying the winning flit and its source index.
module router_out_arbiter #(
  parameter  int NPORTS  = 5,
  parameter  int W       = 256,
  parameter  int CREDITS = 4,
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  router_out_arbiter_if.slave   req,
  input  logic                  credit_return,
  output logic                  out_valid,
  output logic [W-1:0]          out_packet,
  output logic [2:0]            out_src,
  output logic [CW-1:0]         credit_count,
  output logic                  credit_err
);

  localparam int            PW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [PW:0]   NP       = (PW+1)'(NPORTS);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   lock_q, lock_d;
  logic [PW-1:0]   win_idx, xfer_idx;
  logic [PW:0]     cand;
  logic            found;
  logic [NPORTS-1:0] grant;
  logic            xfer;
  logic            has_credit;

  logic            vld_p1;
  logic [W-1:0]    packet_p1;
  logic [2:0]      src_p1;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return (p == PW'(NPORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Return and consume cancel; a return into a full counter is dropped (and flagged).
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cnt,
                                                input logic take, input logic give);
    if (take && !give)                          return cnt - 1'b1;
    else if (give && !take && cnt != CRED_MAX)  return cnt + 1'b1;
    else                                        return cnt;
  endfunction

  assign has_credit = (credit_count != '0);

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = {1'b0, rr_q} + (PW+1)'(k);
      if (cand >= NP) cand = cand - NP;
      if (!found && req.req_valid[cand[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    lock_d   = lock_q;
    grant    = '0;
    xfer_idx = win_idx;
    case (state_q)
      IDLE: begin
        if (found && has_credit) begin
          grant[win_idx] = 1'b1;
          if (req.req_last[win_idx]) begin
            rr_d = next_port(win_idx);
          end else begin
            state_d = LOCKED;
            lock_d  = win_idx;
          end
        end
      end
      LOCKED: begin
        xfer_idx = lock_q;
        if (has_credit && req.req_valid[lock_q]) begin
          grant[lock_q] = 1'b1;
          if (req.req_last[lock_q]) begin
            state_d = IDLE;
            rr_d    = next_port(lock_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer          = |grant;
  assign req.req_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      lock_q       <= '0;
      credit_count <= CRED_MAX;
      credit_err   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      lock_q       <= lock_d;
      credit_count <= credit_next(credit_count, xfer, credit_return);
      if (credit_return && !xfer && credit_count == CRED_MAX) credit_err <= 1'b1;
    end
  end

  // Stage p1: registered output link; payload and source hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      packet_p1 <= '0;
      src_p1    <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        packet_p1 <= req.req_packet[xfer_idx];
        src_p1    <= 3'(xfer_idx);
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_packet = packet_p1;
  assign out_src    = src_p1;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Randomized and directed bench for router_out_arbiter against a rule-level model.
module tb_router_out_arbiter;
  localparam int NP      = 5;
  localparam int W       = 256;
  localparam int CREDITS = 4;
  localparam int CW      = $clog2(CREDITS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic credit_return = 1'b0;
  logic out_valid;
  logic [W-1:0] out_packet;
  logic [2:0] out_src;
  logic [CW-1:0] credit_count;
  logic credit_err;

  int checks = 0;
  int failures = 0;

  router_out_arbiter_if #(.NPORTS(NP), .W(W)) rif ();

  router_out_arbiter #(.NPORTS(NP), .W(W), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst_n(rst_n), .req(rif.slave), .credit_return(credit_return),
    .out_valid(out_valid), .out_packet(out_packet), .out_src(out_src),
    .credit_count(credit_count), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  // Reference model: owner of the link (-1 = free), next-priority port, credits.
  int m_lock, m_rr, m_cred, m_src;
  bit m_err, m_ov;
  logic [W-1:0] m_pkt;

  task automatic model_reset();
    m_lock = -1; m_rr = 0; m_cred = CREDITS; m_err = 0; m_ov = 0; m_pkt = '0; m_src = 0;
  endtask

  function automatic logic [NP-1:0] model_grant(input logic [NP-1:0] v);
    logic [NP-1:0] g = '0;
    if (m_cred == 0) return g;
    if (m_lock >= 0) begin
      if (v[m_lock]) g[m_lock] = 1'b1;
      return g;
    end
    for (int k = 0; k < NP; k++) begin
      if (v[(m_rr + k) % NP]) begin
        g[(m_rr + k) % NP] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_update(input logic [NP-1:0] l, input logic [NP-1:0][W-1:0] pk,
                              input logic cr, input logic [NP-1:0] g);
    int taken = 0;
    m_ov = 0;
    for (int i = 0; i < NP; i++) begin
      if (g[i]) begin
        taken = 1; m_ov = 1; m_pkt = pk[i]; m_src = i;
        if (l[i]) begin m_lock = -1; m_rr = (i + 1) % NP; end
        else m_lock = i;
      end
    end
    m_cred = m_cred - taken + int'(cr);
    if (m_cred > CREDITS) begin m_cred = CREDITS; m_err = 1; end
  endtask

  // Entered after a rising edge; returns 1ns after the next rising edge.
  task automatic step(input logic [NP-1:0] v, input logic [NP-1:0] l, input logic cr,
                      output logic [NP-1:0] rdy_obs, output logic [NP-1:0] rdy_exp);
    logic [NP-1:0][W-1:0] pk;
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < W/32; j++) pk[i][j*32 +: 32] = $urandom;
    rif.req_valid = v; rif.req_last = l; rif.req_packet = pk; credit_return = cr;
    rdy_exp = model_grant(v);
    #3;
    rdy_obs = rif.req_ready;
    @(posedge clk); #1;
    model_update(l, pk, cr, rdy_exp);
  endtask

  task automatic do_reset();
    rif.req_valid = '0; rif.req_last = '0; rif.req_packet = '0; credit_return = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rif.req_valid = '0; rif.req_last = '0; rif.req_packet = '0; credit_return = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (credit_count !== CW'(CREDITS)) begin failures++; $display("FAIL reset_credit got=%0d exp=%0d", credit_count, CREDITS); end
    checks++; if (rif.req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rif.req_ready); end
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL reset_credit_err got=%b exp=0", credit_err); end
    checks++; if (out_src !== 3'd0 || out_packet !== '0) begin failures++; $display("FAIL reset_out_regs src=%0d pkt_nonzero=%b", out_src, |out_packet); end
    rst_n = 1'b1;
  endtask

  task automatic test_rr_fairness();
    logic [NP-1:0] ro, re, exp_g;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(5'b11111, 5'b11111, 1'b1, ro, re);
      exp_g = '0; exp_g[k % NP] = 1'b1;
      checks++; if (ro !== exp_g) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", k, ro, exp_g); end
      checks++; if (out_valid !== 1'b1 || out_src !== 3'(k % NP)) begin failures++; $display("FAIL rr_out_src cyc=%0d got=%0d/%b exp=%0d/1", k, out_src, out_valid, k % NP); end
      checks++; if (out_packet !== m_pkt || credit_count !== CW'(CREDITS)) begin failures++; $display("FAIL rr_payload_credit cyc=%0d cnt=%0d", k, credit_count); end
    end
  endtask

  task automatic test_lock();
    logic [NP-1:0] ro, re;
    logic [NP-1:0] lv [5] = '{5'b01101, 5'b01001, 5'b01101, 5'b01101, 5'b01001};
    logic [NP-1:0] ll [5] = '{5'b01001, 5'b01001, 5'b01001, 5'b01101, 5'b01001};
    logic [NP-1:0] er [5] = '{5'b00100, 5'b00000, 5'b00100, 5'b00100, 5'b01000};
    int es [5] = '{2, 2, 2, 2, 3};
    logic eo [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    step(5'b00010, 5'b00010, 1'b1, ro, re);
    for (int k = 0; k < 5; k++) begin
      step(lv[k], ll[k], 1'b1, ro, re);
      checks++; if (ro !== er[k]) begin failures++; $display("FAIL lock_ready step=%0d got=%b exp=%b", k, ro, er[k]); end
      checks++; if (out_valid !== eo[k] || out_src !== 3'(es[k])) begin failures++; $display("FAIL lock_out step=%0d src=%0d vld=%b exp=%0d/%b", k, out_src, out_valid, es[k], eo[k]); end
      checks++; if (out_packet !== m_pkt) begin failures++; $display("FAIL lock_payload step=%0d", k); end
    end
  endtask

  task automatic test_credits();
    logic [NP-1:0] ro, re;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(5'b00010, 5'b00010, 1'b0, ro, re);
      checks++; if (ro !== (k < 4 ? 5'b00010 : 5'b00000)) begin failures++; $display("FAIL cred_ready k=%0d got=%b", k, ro); end
      checks++; if (credit_count !== CW'(k < 4 ? 3 - k : 0)) begin failures++; $display("FAIL cred_count k=%0d got=%0d exp=%0d", k, credit_count, (k < 4 ? 3 - k : 0)); end
    end
    step(5'b00010, 5'b00010, 1'b1, ro, re);
    checks++; if (ro !== 5'b00000 || credit_count !== CW'(1)) begin failures++; $display("FAIL cred_return_same_cycle ready=%b cnt=%0d exp=0/1", ro, credit_count); end
    step(5'b00010, 5'b00010, 1'b0, ro, re);
    checks++; if (ro !== 5'b00010 || credit_count !== '0 || out_valid !== 1'b1) begin failures++; $display("FAIL cred_one_more ready=%b cnt=%0d vld=%b", ro, credit_count, out_valid); end
    step(5'b00010, 5'b00010, 1'b0, ro, re);
    checks++; if (ro !== 5'b00000 || out_valid !== 1'b0) begin failures++; $display("FAIL cred_exhausted ready=%b vld=%b", ro, out_valid); end
  endtask

  task automatic test_simultaneity();
    logic [NP-1:0] ro, re;
    step('0, '0, 1'b1, ro, re);
    step('0, '0, 1'b1, ro, re);
    checks++; if (credit_count !== CW'(2)) begin failures++; $display("FAIL sim_refill got=%0d exp=2", credit_count); end
    step(5'b00010, 5'b00010, 1'b1, ro, re);
    checks++; if (ro !== 5'b00010 || credit_count !== CW'(2)) begin failures++; $display("FAIL sim_net_zero ready=%b cnt=%0d exp=00010/2", ro, credit_count); end
    step('0, '0, 1'b1, ro, re);
    step('0, '0, 1'b1, ro, re);
    checks++; if (credit_count !== CW'(4) || credit_err !== 1'b0) begin failures++; $display("FAIL sim_full cnt=%0d err=%b exp=4/0", credit_count, credit_err); end
    step('0, '0, 1'b1, ro, re);
    checks++; if (credit_count !== CW'(4) || credit_err !== 1'b1) begin failures++; $display("FAIL sim_overflow cnt=%0d err=%b exp=4/1", credit_count, credit_err); end
    step('0, '0, 1'b0, ro, re);
    checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL sim_sticky err=%b exp=1", credit_err); end
  endtask

  task automatic test_reset_mid_packet();
    logic [NP-1:0] ro, re;
    do_reset();
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL mid_err_cleared got=%b", credit_err); end
    step(5'b10000, 5'b00000, 1'b0, ro, re);
    step(5'b10001, 5'b00000, 1'b0, ro, re);
    checks++; if (ro !== 5'b10000) begin failures++; $display("FAIL mid_locked got=%b exp=10000", ro); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || credit_count !== CW'(CREDITS)) begin failures++; $display("FAIL mid_async vld=%b cnt=%0d", out_valid, credit_count); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(5'b10001, 5'b10001, 1'b0, ro, re);
    checks++; if (ro !== 5'b00001 || out_src !== 3'd0) begin failures++; $display("FAIL mid_in0_wins ready=%b src=%0d", ro, out_src); end
  endtask

  task automatic test_random();
    logic [NP-1:0] ro, re, v, l;
    logic cr;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      v  = NP'($urandom);
      l  = NP'($urandom | $urandom);
      cr = ($urandom_range(0, 9) < 4);
      step(v, l, cr, ro, re);
      checks++; if (ro !== re) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", k, ro, re); end
      checks++; if (out_valid !== m_ov || out_src !== 3'(m_src)) begin failures++; $display("FAIL rnd_out cyc=%0d vld=%b src=%0d exp=%b/%0d", k, out_valid, out_src, m_ov, m_src); end
      checks++; if (out_packet !== m_pkt) begin failures++; $display("FAIL rnd_payload cyc=%0d", k); end
      checks++; if (credit_count !== CW'(m_cred) || credit_err !== m_err) begin failures++; $display("FAIL rnd_credit cyc=%0d cnt=%0d err=%b exp=%0d/%b", k, credit_count, credit_err, m_cred, m_err); end
    end
  endtask

  initial begin
    rif.req_valid = '0; rif.req_last = '0; rif.req_packet = '0;
    test_reset();
    test_rr_fairness();
    test_lock();
    test_credits();
    test_simultaneity();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
